// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller: request op encoding, stack
// command bit positions, FSM state constants and the reject rule.
package stack_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_UPD  = 2'b11;

  localparam int CMD_POP  = 0;
  localparam int CMD_PUSH = 1;
  localparam int CMD_LOAD = 2;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN   = 1'b0;
  localparam state_t ST_FLUSH = 1'b1;

  // A push into a full stack, or a pop/update of an empty one, is rejected.
  function automatic logic op_reject(input logic [1:0] op, input logic is_empty,
                                     input logic is_full);
    case (op)
      OP_PUSH:        return is_full;
      OP_POP, OP_UPD: return is_empty;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Request/response bus between the two requesters and the stack controller.
interface stack_ctrl_if #(parameter int DW = 16);

  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][1:0]    req_op;
  logic [1:0][DW-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/stack_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pri_r names the requester that wins the next
// contention and only moves when a grant is made.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic pri_r;

  // Grant selection from the live requests and the priority pointer.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = pri_r ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Priority pointer: after a grant, favour the other requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pri_r <= 1'b0;
    end else if (|gnt) begin
      pri_r <= gnt[0];
    end else begin
      pri_r <= pri_r;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack controller: arbitrates two requesters onto an external stack, tracks
// its depth, reports one response per grant and can flush the stack empty.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          reset,
  stack_ctrl_if.slave   bus,
  input  logic          flush,
  output logic [2:0]    cmd,
  output logic [DW-1:0] in,
  input  logic [DW-1:0] s0,
  output logic [AW:0]   depth,
  output logic          busy,
  output logic          empty,
  output logic          full
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  state_t        state_r;
  logic [AW:0]   depth_r;
  logic          rsp_valid_r;
  logic          rsp_id_r;
  logic          rsp_err_r;

  logic          grant_en_s;
  logic [1:0]    gnt_s;
  logic          gnt_idx_s;
  logic [1:0]    op_s;
  logic [DW-1:0] data_s;
  logic          empty_s;
  logic          full_s;
  logic          rej_s;
  logic          push_s;
  logic          pop_s;
  logic [2:0]    cmd_s;
  logic [DW-1:0] in_s;

  // A flush request steals the cycle it is sampled in; reset blocks grants too.
  assign grant_en_s = (state_r == ST_RUN) && !flush && !reset;
  assign gnt_idx_s  = gnt_s[1];
  assign empty_s    = (depth_r == '0);
  assign full_s     = (depth_r == DEPTH_C);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (grant_en_s),
    .req   (bus.req_valid),
    .gnt   (gnt_s)
  );

  // Command decode for the granted request, or the drain pops while flushing.
  always_comb begin
    cmd_s  = 3'b000;
    in_s   = '0;
    rej_s  = 1'b0;
    push_s = 1'b0;
    pop_s  = 1'b0;
    op_s   = bus.req_op[gnt_idx_s];
    data_s = bus.req_data[gnt_idx_s];
    if (state_r == ST_FLUSH) begin
      if (!empty_s) begin
        cmd_s[CMD_POP] = 1'b1;
        pop_s          = 1'b1;
      end else begin
        cmd_s = 3'b000;
      end
    end else if (|gnt_s) begin
      rej_s = op_reject(op_s, empty_s, full_s);
      if (!rej_s) begin
        case (op_s)
          OP_PUSH: begin
            cmd_s[CMD_PUSH] = 1'b1;
            cmd_s[CMD_LOAD] = 1'b1;
            in_s            = data_s;
            push_s          = 1'b1;
          end
          OP_POP: begin
            cmd_s[CMD_POP] = 1'b1;
            pop_s          = 1'b1;
          end
          OP_UPD: begin
            cmd_s[CMD_LOAD] = 1'b1;
            in_s            = data_s;
          end
          default: cmd_s = 3'b000;
        endcase
      end else begin
        cmd_s = 3'b000;
      end
    end else begin
      cmd_s = 3'b000;
    end
  end

  // Entry count follows issued pushes and pops only, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_r <= '0;
    end else if (push_s) begin
      depth_r <= depth_r + ONE_C;
    end else if (pop_s) begin
      depth_r <= depth_r - ONE_C;
    end else begin
      depth_r <= depth_r;
    end
  end

  // RUN/FLUSH control; leave FLUSH on the edge that pops the last entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:   state_r <= flush ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state_r <= (depth_r <= ONE_C) ? ST_RUN : ST_FLUSH;
        default:  state_r <= ST_RUN;
      endcase
    end
  end

  // Response bookkeeping, one cycle behind the grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= |gnt_s;
      rsp_id_r    <= gnt_idx_s;
      rsp_err_r   <= rej_s;
    end
  end

  // Response data is the stack top after the operation has taken effect.
  assign bus.rsp_data  = (rsp_valid_r && !empty_s) ? s0 : '0;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.req_ready = gnt_s;
  assign cmd           = cmd_s;
  assign in            = in_s;
  assign depth         = depth_r;
  assign busy          = (state_r == ST_FLUSH);
  assign empty         = empty_s;
  assign full          = full_s;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a small behavioural stack on s0 and a
// response scoreboard drained by an independent monitor.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic          id;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [2:0]    cmd;
  logic [DW-1:0] in_d;
  logic [DW-1:0] s0;
  logic [AW:0]   depth;
  logic          busy, empty, full;

  int   n_vec = 0;
  int   n_err = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;

  logic [DW-1:0] mem [0:7];
  int            sp;

  stack_ctrl_if #(.DW(DW)) bus ();

  stack_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .flush (flush),
    .cmd   (cmd),
    .in    (in_d),
    .s0    (s0),
    .depth (depth),
    .busy  (busy),
    .empty (empty),
    .full  (full)
  );

  always #5 clk = ~clk;

  // Behavioural stack obeying cmd: bit0 pop, bit1 push, bit2 load top.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
    end else if (cmd[1] && sp < 8) begin
      mem[sp] <= in_d;
      sp      <= sp + 1;
    end else if (cmd[0] && sp > 0) begin
      sp <= sp - 1;
    end else if (cmd[2] && sp > 0) begin
      mem[sp-1] <= in_d;
    end
  end
  assign s0 = (sp > 0) ? mem[sp-1] : '0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d data %0h, expected none at %0t",
                 bus.rsp_id, bus.rsp_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        cmp("rsp_id",   32'(bus.rsp_id),   32'(mon_e.id));
        cmp("rsp_err",  32'(bus.rsp_err),  32'(mon_e.err));
        cmp("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
      end
    end
  end

  task automatic set_req(input logic [1:0] v, input logic [1:0] op0, input logic [DW-1:0] d0,
                         input logic [1:0] op1, input logic [DW-1:0] d1);
    bus.req_valid   = v;
    bus.req_op[0]   = op0;
    bus.req_data[0] = d0;
    bus.req_op[1]   = op1;
    bus.req_data[1] = d1;
  endtask

  // Check one cycle mid-period, queue its response, then move past the next edge.
  task automatic step(input logic [1:0] r, input logic [2:0] c, input logic ci,
                      input logic [DW-1:0] i, input int d, input logic b,
                      input logic pe, input rsp_t p);
    @(negedge clk);
    cmp("req_ready", 32'(bus.req_ready), 32'(r));
    cmp("cmd",       32'(cmd),           32'(c));
    if (ci) cmp("in", 32'(in_d), 32'(i));
    cmp("depth", 32'(depth), 32'(d));
    cmp("busy",  32'(busy),  32'(b));
    cmp("empty", 32'(empty), 32'(d == 0));
    cmp("full",  32'(full),  32'(d == DEPTH));
    if (pe) exp_q.push_back(p);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic g;
    set_req(2'b00, OP_NOP, 16'h0000, OP_NOP, 16'h0000);
    #1;
    cmp("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    cmp("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
    step(2'b00, 3'b000, 1'b1, 16'h0000, 0, 1'b0, 1'b0, rsp_t'(0));
    reset = 1'b0;

    // Push then pop from requester 0.
    set_req(2'b01, OP_PUSH, 16'h1234, OP_NOP, 16'h0000);
    step(2'b01, 3'b110, 1'b1, 16'h1234, 0, 1'b0, 1'b1, rsp_t'{1'b0, 1'b0, 16'h1234});
    set_req(2'b01, OP_POP, 16'h0000, OP_NOP, 16'h0000);
    step(2'b01, 3'b001, 1'b1, 16'h0000, 1, 1'b0, 1'b1, rsp_t'{1'b0, 1'b0, 16'h0000});
    set_req(2'b00, OP_NOP, 16'h0000, OP_NOP, 16'h0000);
    step(2'b00, 3'b000, 1'b1, 16'h0000, 0, 1'b0, 1'b0, rsp_t'(0));

    // Underflow from requester 1.
    set_req(2'b10, OP_NOP, 16'h0000, OP_POP, 16'h0000);
    step(2'b10, 3'b000, 1'b0, 16'h0000, 0, 1'b0, 1'b1, rsp_t'{1'b1, 1'b1, 16'h0000});
    set_req(2'b00, OP_NOP, 16'h0000, OP_NOP, 16'h0000);
    step(2'b00, 3'b000, 1'b1, 16'h0000, 0, 1'b0, 1'b0, rsp_t'(0));

    // Contention: both push for four cycles, grants alternate 0,1,0,1.
    set_req(2'b11, OP_PUSH, 16'h0A0A, OP_PUSH, 16'h0B0B);
    for (int k = 0; k < 4; k++) begin
      g = 1'(k % 2);
      step(g ? 2'b10 : 2'b01, 3'b110, 1'b1, g ? 16'h0B0B : 16'h0A0A, k, 1'b0, 1'b1,
           rsp_t'{g, 1'b0, g ? 16'h0B0B : 16'h0A0A});
    end

    // Overflow at DEPTH, then update and pop.
    set_req(2'b01, OP_PUSH, 16'h5555, OP_NOP, 16'h0000);
    step(2'b01, 3'b000, 1'b0, 16'h0000, 4, 1'b0, 1'b1, rsp_t'{1'b0, 1'b1, 16'h0B0B});
    set_req(2'b10, OP_NOP, 16'h0000, OP_UPD, 16'h7777);
    step(2'b10, 3'b100, 1'b1, 16'h7777, 4, 1'b0, 1'b1, rsp_t'{1'b1, 1'b0, 16'h7777});
    set_req(2'b01, OP_POP, 16'h0000, OP_NOP, 16'h0000);
    step(2'b01, 3'b001, 1'b1, 16'h0000, 4, 1'b0, 1'b1, rsp_t'{1'b0, 1'b0, 16'h0A0A});

    // Flush from depth 3 with a pending push held off throughout.
    flush = 1'b1;
    set_req(2'b01, OP_PUSH, 16'h9999, OP_NOP, 16'h0000);
    step(2'b00, 3'b000, 1'b1, 16'h0000, 3, 1'b0, 1'b0, rsp_t'(0));
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 3'b001, 1'b1, 16'h0000, 3 - k, 1'b1, 1'b0, rsp_t'(0));
    end
    set_req(2'b00, OP_NOP, 16'h0000, OP_NOP, 16'h0000);
    step(2'b00, 3'b000, 1'b1, 16'h0000, 0, 1'b0, 1'b0, rsp_t'(0));

    // Reset the cycle after a grant: the pending response is dropped.
    set_req(2'b10, OP_NOP, 16'h0000, OP_PUSH, 16'h4321);
    step(2'b10, 3'b110, 1'b1, 16'h4321, 0, 1'b0, 1'b0, rsp_t'(0));
    reset = 1'b1;
    set_req(2'b00, OP_NOP, 16'h0000, OP_NOP, 16'h0000);
    #1;
    cmp("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    cmp("rst_mid_depth",     32'(depth),         32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_req(2'b11, OP_PUSH, 16'h0001, OP_PUSH, 16'h0002);
    step(2'b01, 3'b110, 1'b1, 16'h0001, 0, 1'b0, 1'b1, rsp_t'{1'b0, 1'b0, 16'h0001});
    set_req(2'b00, OP_NOP, 16'h0000, OP_NOP, 16'h0000);
    step(2'b00, 3'b000, 1'b1, 16'h0000, 1, 1'b0, 1'b0, rsp_t'(0));
    step(2'b00, 3'b000, 1'b1, 16'h0000, 1, 1'b0, 1'b0, rsp_t'(0));

    cmp("rsp_outstanding", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, meaning stack address width.
REQ-002 SHALL have parameter DW, default 16, meaning data width.
REQ-003 SHALL have parameter DEPTH, default 2**AW, meaning maximum entries held (register tiers plus memory).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 2, meaning per-requester request valid (index 0, 1).
REQ-007 SHALL have port req_ready, output, 2, meaning per-requester request accepted this cycle.
REQ-008 SHALL have port req_op, input, 2x2, meaning per-requester op: 00 NOP, 01 POP, 10 PUSH, 11 UPD (replace top).
REQ-009 SHALL have port req_data, input, 2xDW, meaning per-requester push/update data.
REQ-010 SHALL have port flush, input, 1, meaning a level request to empty the stack.
REQ-011 SHALL have port cmd, output, 3, meaning stack command: bit0 pop, bit1 push, bit2 load top from in.
REQ-012 SHALL have port in, output, DW, meaning data to the stack.
REQ-013 SHALL have port s0, input, DW, meaning current stack top.
REQ-014 SHALL have port rsp_valid, output, 1, meaning a response is present.
REQ-015 SHALL have port rsp_id, output, 1, meaning the requester that owns the response.
REQ-016 SHALL have port rsp_data, output, DW, meaning the stack top after the operation.
REQ-017 SHALL have port rsp_err, output, 1, meaning the operation was rejected (overflow/underflow).
REQ-018 SHALL have ports depth (output, AW+1, current entry count), busy (output, 1, flush in progress) and empty/full (outputs, 1 each).

Function
REQ-019 SHALL implement an FSM with states RUN and FLUSH.
REQ-020 SHALL accept at most one request per cycle in RUN; the arbiter is round-robin: on a contention cycle the requester not granted last wins, and the pointer updates only on a grant.
REQ-021 SHALL drive req_ready combinationally from the grant; req_ready is 0 for both requesters in FLUSH.
REQ-022 SHALL issue the following commands for a granted request: PUSH gives cmd=110 with in=req_data; POP gives cmd=001; UPD gives cmd=100 with in=req_data; NOP gives cmd=000.
REQ-023 SHALL suppress the command (cmd=000) for a PUSH when depth==DEPTH or a POP/UPD when depth==0, and set rsp_err for that operation.
REQ-024 SHALL drive cmd=000 and in=0 on every cycle without a grant.
REQ-025 SHALL present the response exactly one cycle after the grant: rsp_valid=1, rsp_id=granted index, rsp_err as computed, rsp_data=s0 (the post-operation top, 0 when the result is empty).
REQ-026 SHALL increment depth on an issued PUSH and decrement it on an issued POP; UPD, NOP and rejected ops leave depth unchanged.
REQ-027 SHALL not wrap depth past DEPTH or below 0.
REQ-028 SHALL sample flush in RUN: when flush=1, the FSM enters FLUSH on the next edge and no grant is made that cycle.
REQ-029 SHALL issue cmd=001 every cycle in FLUSH while depth>0, with no response generated.
REQ-030 SHALL return the FSM to RUN on the edge where depth reaches 0; flush=0 mid-FLUSH does not abort.
REQ-031 SHALL assert busy exactly while in FLUSH.
REQ-032 SHALL assert empty when depth==0 and full when depth==DEPTH.

Reset
REQ-033 SHALL on reset force: FSM=RUN, depth=0, round-robin pointer to favour requester 0, cmd=000, in=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, req_ready=00.
REQ-034 SHALL discard any in-flight response when reset is asserted mid-operation; the first legal grant is in the first cycle after deassertion.

Structure
REQ-035 SHALL take the op encoding, cmd bit positions and FSM state enum from a shared package, stack_pkg.
REQ-036 SHALL contain one sub-module, rr_arb2: a two-way round-robin arbiter with the pointer register inside.

Verification
REQ-037 SHALL verify a push then a pop: req0 PUSH 0x1234, then req0 POP gives cmd 110 then 001; responses are data 0x1234/err0 for the push, then err0, with depth 1 then 0.
REQ-038 SHALL verify contention: both requesters hold PUSH for 4 cycles, giving grants 0,1,0,1 and rsp_id 0,1,0,1, with final depth 4.
REQ-039 SHALL verify underflow: POP at depth 0 gives cmd 000, rsp_err=1 one cycle later, and depth stays 0.
REQ-040 SHALL verify overflow: with DEPTH=4 after 4 pushes, a fifth PUSH gives cmd 000, rsp_err=1 and depth 4.
REQ-041 SHALL verify flush: at depth 3, flush for 1 cycle gives busy for 3 cycles, three cmd 001, req_ready=00 throughout, then RUN with empty=1.
REQ-042 SHALL verify reset mid-operation: reset asserted the cycle after a grant gives rsp_valid 0 and depth 0 immediately.
